// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: data width, FSM state
// encodings, port identifiers and the alignment helper.
package mem_arbiter_pkg;

  localparam int WORD  = 64;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Accesses are whole 8-byte words; any low address bit set is an error.
  function automatic logic misaligned(input logic [2:0] lsb);
    return lsb != 3'b000;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Two-requester round-robin chooser. On a tie the port not granted last
// wins; the remembered winner updates on every grant taken.
module rr_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_if,
  input  logic       req_d,
  input  logic       en,
  output logic [1:0] gnt      // one-hot: bit 0 = fetch, bit 1 = data
);

  port_e last_grant;

  // Pick a winner while the arbiter is free to accept a request.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    gnt = 2'b00;
    if (en) begin
      if (req_if && req_d) gnt = (last_grant == PORT_D) ? 2'b01 : 2'b10;
      else                 gnt = {req_d, req_if};
    end
  end

  // Remember the last winner; reset favours fetch on the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   last_grant <= PORT_D;
    else if (en && (req_if || req_d)) last_grant <= gnt[1] ? PORT_D : PORT_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency data
// memory. One transaction in flight: grant, LATENCY access cycles, one
// response cycle. Misaligned addresses skip the memory and answer with err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD    = mem_arbiter_pkg::WORD,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [WORD-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [WORD-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [WORD-1:0] d_rdata,
  output logic            d_err,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  port_e              port_q;
  logic               we_q, err_q;
  logic [WORD-1:0]    addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [1:0]         gnt;
  logic [WORD-1:0]    sel_addr;
  logic               sel_bad;
  logic               last_access;

  rr_arbiter u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_if  (if_req),
    .req_d   (d_req),
    .en      (state == IDLE),
    .gnt     (gnt)
  );

  assign sel_addr    = gnt[1] ? d_addr : if_addr;
  assign sel_bad     = misaligned(sel_addr[2:0]);
  assign last_access = (state == ACCESS) && (cnt == '0);

  // Next-state and access counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (gnt != 2'b00) begin
        if (sel_bad) state_nxt = RESP;
        else begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch the granted transaction; memory address/data stay stable through ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt != 2'b00) begin
      port_q  <= gnt[1] ? PORT_D : PORT_IF;
      we_q    <= gnt[1] & d_we;
      err_q   <= sel_bad;
      addr_q  <= sel_addr;
      wdata_q <= gnt[1] ? d_wdata : '0;
    end
  end

  // Per-port read data: zero for a misaligned grant, memory data on the
  // final read cycle, otherwise held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if ((gnt != 2'b00) && sel_bad) begin
      if (gnt[1]) d_rdata_q  <= '0;
      else        if_rdata_q <= '0;
    end else if (last_access && !we_q) begin
      if (port_q == PORT_D) d_rdata_q  <= mem_rdata;
      else                  if_rdata_q <= mem_rdata;
    end
  end

  // Strobes come straight from the state register so reset drops them at once;
  // grants are masked by reset because they follow the live requests.
  always_comb begin
    if_gnt    = gnt[0] & reset_n;
    d_gnt     = gnt[1] & reset_n;
    mem_read  = (state == ACCESS) && !we_q;
    mem_write = (state == ACCESS) &&  we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rvalid = (state == RESP) && (port_q == PORT_IF);
    d_rvalid  = (state == RESP) && (port_q == PORT_D);
    if_err    = if_rvalid & err_q;
    d_err     = d_rvalid & err_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, data write, round-robin ties,
// misaligned access, reset mid-access, and a LATENCY=1 build.
module tb_mem_arbiter;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 2 instance
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [W-1:0]  if_addr, if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [W-1:0]  d_addr, d_wdata, d_rdata;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, busy;

  // LATENCY = 1 instance
  logic          l1_if_req, l1_if_gnt, l1_if_rvalid, l1_if_err;
  logic [W-1:0]  l1_if_addr, l1_if_rdata;
  logic          l1_d_req, l1_d_we, l1_d_gnt, l1_d_rvalid, l1_d_err;
  logic [W-1:0]  l1_d_addr, l1_d_wdata, l1_d_rdata;
  logic [W-1:0]  l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic          l1_mem_read, l1_mem_write, l1_busy;

  mem_arbiter #(.WORD(W), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.WORD(W), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
    .if_rdata(l1_if_rdata), .if_err(l1_if_err),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata), .d_gnt(l1_d_gnt),
    .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata), .d_err(l1_d_err),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
    .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    l1_if_req = 1'b0; l1_if_addr = '0;
    l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;
    l1_mem_rdata = '0;

    // Reset: outputs held at zero even with requests pending
    #12;
    check("rst_if_gnt", 64'(if_gnt), 64'd0);
    check("rst_d_gnt",  64'(d_gnt),  64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_mem_rd", 64'(mem_read), 64'd0);
    check("rst_rdata",  if_rdata, 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    reset_n = 1'b1;
    tick();

    // Single fetch read at 0x10, memory returns 0xDEAD
    if_req = 1'b1; if_addr = 64'h10; mem_rdata = 64'hDEAD;
    #1;
    check("rd_if_gnt_c0", 64'(if_gnt), 64'd1);
    check("rd_d_gnt_c0",  64'(d_gnt),  64'd0);
    check("rd_busy_c0",   64'(busy),   64'd0);
    tick();
    if_req = 1'b0;
    check("rd_mem_rd_c1", 64'(mem_read), 64'd1);
    check("rd_mem_wr_c1", 64'(mem_write), 64'd0);
    check("rd_addr_c1",   mem_addr, 64'h10);
    check("rd_busy_c1",   64'(busy), 64'd1);
    tick();
    check("rd_mem_rd_c2", 64'(mem_read), 64'd1);
    check("rd_rvalid_c2", 64'(if_rvalid), 64'd0);
    tick();
    check("rd_rvalid_c3", 64'(if_rvalid), 64'd1);
    check("rd_rdata_c3",  if_rdata, 64'hDEAD);
    check("rd_err_c3",    64'(if_err), 64'd0);
    check("rd_mem_rd_c3", 64'(mem_read), 64'd0);
    check("rd_d_rvalid_c3", 64'(d_rvalid), 64'd0);
    tick();
    check("rd_rvalid_c4", 64'(if_rvalid), 64'd0);
    check("rd_busy_c4",   64'(busy), 64'd0);
    check("rd_hold_c4",   if_rdata, 64'hDEAD);

    // Data write 0x55 to 0x20
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h55;
    #1;
    check("wr_d_gnt",  64'(d_gnt),  64'd1);
    check("wr_if_gnt", 64'(if_gnt), 64'd0);
    check("wr_mem_rd_c0", 64'(mem_read), 64'd0);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = 64'h0;
    for (int c = 1; c <= 2; c++) begin
      check($sformatf("wr_mem_wr_c%0d", c), 64'(mem_write), 64'd1);
      check($sformatf("wr_mem_rd_c%0d", c), 64'(mem_read), 64'd0);
      check($sformatf("wr_addr_c%0d", c),   mem_addr, 64'h20);
      check($sformatf("wr_wdata_c%0d", c),  mem_wdata, 64'h55);
      tick();
    end
    check("wr_d_rvalid", 64'(d_rvalid), 64'd1);
    check("wr_d_err",    64'(d_err), 64'd0);
    check("wr_mem_wr_c3", 64'(mem_write), 64'd0);
    check("wr_mem_rd_c3", 64'(mem_read), 64'd0);
    check("wr_if_rvalid", 64'(if_rvalid), 64'd0);
    tick();
    check("wr_d_rvalid_c4", 64'(d_rvalid), 64'd0);

    // Round-robin from reset: both ports request continuously
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 64'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
    mem_rdata = 64'hBEEF;
    #1;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("rr_if_gnt_c%0d", c),    64'(if_gnt),    64'(c % 8 == 0));
      check($sformatf("rr_d_gnt_c%0d", c),     64'(d_gnt),     64'(c % 8 == 4));
      check($sformatf("rr_if_rvalid_c%0d", c), 64'(if_rvalid), 64'(c % 8 == 3));
      check($sformatf("rr_d_rvalid_c%0d", c),  64'(d_rvalid),  64'(c % 8 == 7));
      if (c == 15) begin
        check("rr_d_rdata", d_rdata, 64'hBEEF);
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      tick();
    end
    wait_idle();

    // Misaligned data read at 0x23
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h23;
    #1;
    check("mis_d_gnt", 64'(d_gnt), 64'd1);
    tick();
    d_req = 1'b0;
    check("mis_mem_rd",   64'(mem_read), 64'd0);
    check("mis_mem_wr",   64'(mem_write), 64'd0);
    check("mis_d_rvalid", 64'(d_rvalid), 64'd1);
    check("mis_d_err",    64'(d_err), 64'd1);
    check("mis_d_rdata",  d_rdata, 64'd0);
    tick();
    check("mis_d_rvalid_c2", 64'(d_rvalid), 64'd0);
    check("mis_d_err_c2",    64'(d_err), 64'd0);
    check("mis_busy_c2",     64'(busy), 64'd0);

    // Reset during the second ACCESS cycle of a fetch read
    if_req = 1'b1; if_addr = 64'h10;
    #1;
    check("ra_if_gnt", 64'(if_gnt), 64'd1);
    tick();
    if_req = 1'b0;
    check("ra_mem_rd_c1", 64'(mem_read), 64'd1);
    tick();
    check("ra_mem_rd_c2", 64'(mem_read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ra_mem_rd_async", 64'(mem_read), 64'd0);
    check("ra_busy_async",   64'(busy), 64'd0);
    tick();
    check("ra_no_rvalid", 64'(if_rvalid), 64'd0);
    #2;
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 64'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
    #1;
    check("ra_tie_if_gnt", 64'(if_gnt), 64'd1);
    check("ra_tie_d_gnt",  64'(d_gnt),  64'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    wait_idle();

    // LATENCY = 1 build: grant-to-rvalid of 2 cycles
    l1_if_req = 1'b1; l1_if_addr = 64'h40; l1_mem_rdata = 64'h1234;
    #1;
    check("l1_gnt", 64'(l1_if_gnt), 64'd1);
    tick();
    l1_if_req = 1'b0;
    check("l1_mem_rd_c1", 64'(l1_mem_read), 64'd1);
    check("l1_rvalid_c1", 64'(l1_if_rvalid), 64'd0);
    tick();
    check("l1_rvalid_c2", 64'(l1_if_rvalid), 64'd1);
    check("l1_rdata_c2",  l1_if_rdata, 64'h1234);
    check("l1_mem_rd_c2", 64'(l1_mem_read), 64'd0);
    tick();
    check("l1_rvalid_c3", 64'(l1_if_rvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
